// File: rtl/exception_arbiter.sv
// Prioritising, nesting exception controller: sync/edge-detect, pending latch, arbitration, 3-deep EPC stack.
// Latency: a source rise sampled at edge N is pending after N+2 and is taken (has_exp) at the next eligible edge.
// Backpressure: none; requests wait in pending while masked, outranked by the in-service level, or during TAKE.
module exception_arbiter #(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [31:0] HANDLER_BASE   = 32'h0000_0100,
  parameter logic [31:0] HANDLER_STRIDE = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  exp_src,
  input  logic [31:0] cpu_pc,
  input  logic        eret,
  input  logic        mask_we,
  input  logic [2:0]  mask_din,
  output logic        has_exp,
  output logic [31:0] handler_pc,
  output logic [1:0]  exp_cause,
  output logic [31:0] epc_out,
  output logic [2:0]  in_service,
  output logic        exp_block,
  output logic [2:0]  pending
);

  typedef enum logic {RUN = 1'b0, TAKE = 1'b1} state_t;

  // Edge detection stays disarmed until the synchroniser and the previous-value
  // flop hold real post-reset samples, so a level held high across reset
  // release is not mistaken for a fresh rise.
  localparam int WARM = SYNC_STAGES + 1;
  localparam int WW   = $clog2(WARM + 1);

  state_t        state_q, state_d;
  logic [2:0]    sync_q [SYNC_STAGES];
  logic [2:0]    sync_prev;
  logic [WW-1:0] warm_cnt;
  logic          armed;
  logic [2:0]    rise;
  logic [2:0]    mask;
  logic [1:0]    sp;
  logic [31:0]   stack [3];
  logic [1:0]    cause;
  logic [2:0]    above;
  logic [2:0]    top_onehot;
  logic [2:0]    elig;
  logic [1:0]    winner;
  logic [2:0]    win_onehot;
  logic          pop;
  logic          take;

  // Input synchroniser chain, previous-value flop and warm-up counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      sync_prev <= '0;
      warm_cnt  <= '0;
    end else begin
      sync_q[0] <= exp_src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      sync_prev <= sync_q[SYNC_STAGES-1];
      if (!armed) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign armed = (warm_cnt == WW'(WARM));
  assign rise  = armed ? (sync_q[SYNC_STAGES-1] & ~sync_prev) : 3'b000;

  // Current level as a one-hot of the top in-service bit, and the set of sources above it.
  always_comb begin
    above      = 3'b111;
    top_onehot = 3'b000;
    if (in_service[2]) begin
      above      = 3'b000;
      top_onehot = 3'b100;
    end else if (in_service[1]) begin
      above      = 3'b100;
      top_onehot = 3'b010;
    end else if (in_service[0]) begin
      above      = 3'b110;
      top_onehot = 3'b001;
    end
  end

  // Arbitration: highest unmasked pending source above the current level.
  always_comb begin
    elig   = pending & ~mask & above;
    winner = 2'd0;
    if (elig[2])      winner = 2'd2;
    else if (elig[1]) winner = 2'd1;
    win_onehot = 3'b001 << winner;
    pop  = (state_q == RUN) && eret && (sp != 2'd0);
    take = (state_q == RUN) && !pop && (elig != 3'b000) && (sp != 2'd3);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state and the handler-entry outputs, which only exist in TAKE.
  always_comb begin
    state_d    = state_q;
    has_exp    = 1'b0;
    exp_cause  = 2'd0;
    handler_pc = 32'h0;
    case (state_q)
      RUN:  if (take) state_d = TAKE;
      TAKE: begin
        state_d    = RUN;
        has_exp    = 1'b1;
        exp_cause  = cause;
        handler_pc = HANDLER_BASE + HANDLER_STRIDE * {30'h0, cause};
      end
      default: state_d = RUN;
    endcase
  end

  // Pending, mask, in-service set, EPC stack and latched cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      mask       <= '0;
      in_service <= '0;
      sp         <= '0;
      cause      <= '0;
      for (int k = 0; k < 3; k++) stack[k] <= '0;
    end else begin
      // A rise on the same edge as the take re-arms the bit: set wins.
      pending <= (pending & ~(take ? win_onehot : 3'b000)) | rise;
      if (mask_we) mask <= mask_din;
      if (pop) begin
        in_service <= in_service & ~top_onehot;
        sp         <= sp - 2'd1;
      end else if (take) begin
        in_service <= in_service | win_onehot;
        sp         <= sp + 2'd1;
        cause      <= winner;
        for (int k = 0; k < 3; k++)
          if (sp == 2'(k)) stack[k] <= cpu_pc;
      end
    end
  end

  // Top of EPC stack; zero when empty.
  always_comb begin
    epc_out = 32'h0;
    for (int k = 0; k < 3; k++)
      if (sp == 2'(k + 1)) epc_out = stack[k];
  end

  assign exp_block = (state_q == TAKE) || (in_service != 3'b000);

endmodule

// File: tb/tb_exception_arbiter.sv
// Bench for exception_arbiter: directed scenarios then random traffic against a queue-based reference model.
// Handler entries are pushed to a scoreboard by the model and popped by a monitor when has_exp is seen.
// All waits are bounded; summary line reports errors and total checks.
module tb_exception_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  exp_src = 3'b000;
  logic [31:0] cpu_pc = 32'h0;
  logic        eret = 1'b0;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_din = 3'b000;
  logic        has_exp;
  logic [31:0] handler_pc;
  logic [1:0]  exp_cause;
  logic [31:0] epc_out;
  logic [2:0]  in_service;
  logic        exp_block;
  logic [2:0]  pending;

  int errors = 0;
  int checks = 0;

  exception_arbiter dut (
    .clk(clk), .reset(reset), .exp_src(exp_src), .cpu_pc(cpu_pc), .eret(eret),
    .mask_we(mask_we), .mask_din(mask_din), .has_exp(has_exp), .handler_pc(handler_pc),
    .exp_cause(exp_cause), .epc_out(epc_out), .in_service(in_service),
    .exp_block(exp_block), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [1:0] cause; logic [31:0] epc; } entry_t;
  entry_t      sb[$];
  int          lvl_stk[$];
  logic [31:0] pc_stk[$];
  bit   [2:0]  m_pend = 0, m_mask = 0, s1 = 0, s2 = 0, s3 = 0;
  int          nsamp = 0;
  bit          m_take = 0;

  function automatic logic [2:0] m_inserv();
    logic [2:0] r = 3'b000;
    foreach (lvl_stk[i]) r[lvl_stk[i]] = 1'b1;
    return r;
  endfunction

  // Model advances on every clock edge; async reset clears it immediately.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 0; m_mask = 0; s1 = 0; s2 = 0; s3 = 0; nsamp = 0; m_take = 0;
      lvl_stk.delete(); pc_stk.delete(); sb.delete();
    end else begin
      bit [2:0] rise;
      bit       nt;
      int       lvl, w;
      rise = (nsamp >= 3) ? (s2 & ~s3) : 3'b000;
      s3 = s2; s2 = s1; s1 = exp_src;
      if (nsamp < 3) nsamp++;
      nt = 0;
      if (!m_take) begin
        if (eret && lvl_stk.size() > 0) begin
          void'(lvl_stk.pop_back());
          void'(pc_stk.pop_back());
        end else begin
          lvl = (lvl_stk.size() > 0) ? lvl_stk[$] : -1;
          w = -1;
          for (int i = 2; i >= 0; i--)
            if (w < 0 && i > lvl && m_pend[i] && !m_mask[i]) w = i;
          if (w >= 0 && lvl_stk.size() < 3) begin
            lvl_stk.push_back(w);
            pc_stk.push_back(cpu_pc);
            m_pend[w] = 1'b0;
            sb.push_back('{32'h100 + 32'h40 * w, 2'(w), cpu_pc});
            nt = 1;
          end
        end
      end
      m_take = nt;
      m_pend |= rise;
      if (mask_we) m_mask = mask_din;
    end
  end

  // Monitor: compare visible state every cycle, pop scoreboard on handler entry.
  always @(negedge clk) begin
    chk("has_exp", 32'(has_exp), 32'(m_take));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("in_service", 32'(in_service), 32'(m_inserv()));
    chk("epc_out", epc_out, (pc_stk.size() > 0) ? pc_stk[$] : 32'h0);
    chk("exp_block", 32'(exp_block), 32'(m_take || lvl_stk.size() > 0));
    if (has_exp) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_has_exp actual=1 expected=0 at %0t", $time);
      end else begin
        entry_t e;
        e = sb.pop_front();
        chk("handler_pc", handler_pc, e.pc);
        chk("exp_cause", 32'(exp_cause), 32'(e.cause));
        chk("take_epc", epc_out, e.epc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; cyc(1); eret = 1'b0;
  endtask

  task automatic write_mask(input logic [2:0] m);
    mask_we = 1'b1; mask_din = m; cyc(1); mask_we = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    cyc(3);
    chk("reset_has_exp", 32'(has_exp), 32'h0);
    chk("reset_epc", epc_out, 32'h0);
    reset = 1'b1;
    cyc(6);

    // Single request, then eret.
    cpu_pc = 32'h40; exp_src = 3'b001; cyc(6);
    chk("single_in_service", 32'(in_service), 32'h1);
    chk("single_epc", epc_out, 32'h40);
    pulse_eret(); cyc(2);
    chk("single_after_eret", 32'(in_service), 32'h0);
    exp_src = 3'b000; cyc(3);

    // Simultaneous src0 + src2.
    cpu_pc = 32'h80; exp_src = 3'b101; cyc(6);
    chk("simul_in_service", 32'(in_service), 32'h4);
    chk("simul_pending0", 32'(pending), 32'h1);
    pulse_eret(); cyc(4); pulse_eret(); cyc(2);
    exp_src = 3'b000; cyc(3);

    // Nesting: src0, then src1 preempts at 0x104.
    cpu_pc = 32'h40; exp_src = 3'b001; cyc(6);
    cpu_pc = 32'h104; exp_src = 3'b011; cyc(6);
    chk("nest_in_service", 32'(in_service), 32'h3);
    chk("nest_epc", epc_out, 32'h104);
    pulse_eret(); cyc(1);
    chk("nest_epc_outer", epc_out, 32'h40);
    pulse_eret(); cyc(2);
    exp_src = 3'b000; cyc(3);

    // Lower source does not preempt.
    exp_src = 3'b100; cyc(6);
    exp_src = 3'b110; cyc(6);
    chk("nopre_pending", 32'(pending), 32'h2);
    chk("nopre_in_service", 32'(in_service), 32'h4);
    pulse_eret(); cyc(4); pulse_eret(); cyc(2);
    exp_src = 3'b000; cyc(3);

    // Masking holds src1 pending until unmasked.
    write_mask(3'b010);
    exp_src = 3'b010; cyc(6);
    chk("mask_pending", 32'(pending), 32'h2);
    chk("mask_in_service", 32'(in_service), 32'h0);
    write_mask(3'b000); cyc(3);
    chk("unmask_in_service", 32'(in_service), 32'h2);
    pulse_eret(); cyc(2);
    exp_src = 3'b000; cyc(3);

    // eret with an empty stack.
    pulse_eret(); cyc(2);
    chk("eret_empty_block", 32'(exp_block), 32'h0);

    // Reset asserted in the TAKE cycle.
    exp_src = 3'b100;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (has_exp) seen = 1;
    end
    chk("take_seen_before_reset", 32'(seen), 32'h1);
    reset = 1'b0; #1;
    chk("rst_has_exp", 32'(has_exp), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_in_service", 32'(in_service), 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    cyc(2);
    reset = 1'b1;
    cyc(10);
    chk("held_high_no_retrigger", 32'(pending | in_service), 32'h0);
    exp_src = 3'b000; cyc(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(3) == 0) exp_src[b] = ~exp_src[b];
      cpu_pc   = {$urandom_range(32'h3fff_ffff), 2'b00};
      eret     = ($urandom_range(5) == 0);
      mask_we  = ($urandom_range(9) == 0);
      mask_din = 3'($urandom_range(7));
      cyc(1);
    end
    eret = 1'b0; mask_we = 1'b0; exp_src = 3'b000;
    cyc(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
